// File: rtl/err_coder_pkg.sv
// Shared definitions for the pulse-count error coder and the trigger-side decoder.
package err_coder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int ERR_CODE_DEF  = 1;
   localparam int STOP_CODE_DEF = 2;
   localparam int WARN_CODE_DEF = 3;

endpackage

// File: rtl/pulse_frame_tx.sv
// Serialises one pulse-count frame (code high cycles inside FRAME_LEN) followed by a forced-low gap.
//
// state | meaning
// IDLE  | line low, ready to accept a frame
// SEND  | frame bits on the line, cnt = index of bit currently driven
// GAP   | forced low, gcnt = gap cycle currently driven (1..GAP_LEN)
module pulse_frame_tx
   import err_coder_pkg::*;
#(
   parameter int FRAME_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int CODE_W    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [CODE_W-1:0] code,
   output logic              err_out,
   output logic              busy,
   output logic              ready
);

   localparam int                GAP_W    = $clog2(GAP_LEN + 1);
   localparam logic [CODE_W-1:0] LAST_BIT = CODE_W'(FRAME_LEN - 1);
   localparam logic [GAP_W-1:0]  LAST_GAP = GAP_W'(GAP_LEN);

   state_t            state;
   logic [CODE_W-1:0] cnt;
   logic [CODE_W-1:0] code_r;
   logic [GAP_W-1:0]  gcnt;
   logic              start;

   // The last gap cycle can hand over directly to the next frame, keeping frames back-to-back.
   assign ready = (state == IDLE) || ((state == GAP) && (gcnt == LAST_GAP));
   assign start = load && ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         code_r  <= '0;
         gcnt    <= '0;
         err_out <= 1'b0;
         busy    <= 1'b0;
      end else if (start) begin
         state   <= SEND;
         code_r  <= code;
         cnt     <= '0;
         err_out <= (code != '0);
         busy    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               err_out <= 1'b0;
               busy    <= 1'b0;
            end
            SEND: begin
               if (cnt == LAST_BIT) begin
                  state   <= GAP;
                  gcnt    <= GAP_W'(1);
                  err_out <= 1'b0;
               end else begin
                  cnt     <= cnt + 1'b1;
                  err_out <= ((cnt + 1'b1) < code_r);
               end
            end
            GAP: begin
               err_out <= 1'b0;
               if (gcnt == LAST_GAP) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               err_out <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/error_encoder_mc.sv
// Multi-channel error coder: queues ERROR/STOP/WARNING events and sends them as pulse-count frames.
module error_encoder_mc
   import err_coder_pkg::*;
#(
   parameter int N_ERR     = 4,
   parameter int FRAME_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int ERR_CODE  = ERR_CODE_DEF,
   parameter int STOP_CODE = STOP_CODE_DEF,
   parameter int WARN_CODE = WARN_CODE_DEF,
   parameter int DROP_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              live_rising,
   input  logic [N_ERR-1:0]  err_in,
   input  logic              stop_rising,
   input  logic              stop_falling,
   input  logic              warn_in,
   output logic              err_out,
   output logic              busy,
   output logic              err_sent,
   output logic [N_ERR-1:0]  err_latched,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int CODE_W = $clog2(FRAME_LEN + 1);

   if ((FRAME_LEN <= ERR_CODE) || (FRAME_LEN <= STOP_CODE) || (FRAME_LEN <= WARN_CODE) ||
       (GAP_LEN < 1)) begin : g_param_check
      $error("error_encoder_mc: FRAME_LEN must exceed every code and GAP_LEN must be >= 1");
   end

   logic              err_pend;
   logic              stop_pend;
   logic              warn_pend;
   logic              warn_q;
   logic              ready;
   logic              load;
   logic [CODE_W-1:0] code_sel;
   logic              clr_err;
   logic              clr_stop;
   logic              clr_warn;
   logic              set_err;
   logic              stop_ev;
   logic              warn_ev;
   logic              drop_stop;
   logic              drop_warn;
   logic [DROP_W:0]   drop_sum;

   always_comb begin
      load     = ready && (err_pend || stop_pend || warn_pend);
      clr_err  = load && err_pend;
      clr_stop = load && !err_pend && stop_pend;
      clr_warn = load && !err_pend && !stop_pend;
      if (err_pend)       code_sel = CODE_W'(ERR_CODE);
      else if (stop_pend) code_sel = CODE_W'(STOP_CODE);
      else                code_sel = CODE_W'(WARN_CODE);

      // A live_rising cycle already belongs to the new spill, so the old err_sent no longer blocks.
      set_err   = (|err_in) && !(err_sent && !live_rising) && !err_pend;
      stop_ev   = stop_rising || stop_falling;
      warn_ev   = warn_in && !warn_q;
      drop_stop = stop_ev && stop_pend && !clr_stop && !live_rising;
      drop_warn = warn_ev && warn_pend && !clr_warn && !live_rising;
      drop_sum  = {1'b0, drop_cnt} + (DROP_W + 1)'(drop_stop) + (DROP_W + 1)'(drop_warn);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pend    <= 1'b0;
         stop_pend   <= 1'b0;
         warn_pend   <= 1'b0;
         warn_q      <= 1'b0;
         err_sent    <= 1'b0;
         err_latched <= '0;
         drop_cnt    <= '0;
      end else begin
         warn_q <= warn_in;

         if (set_err)                                err_pend <= 1'b1;
         else if (clr_err || (live_rising && !(|err_in))) err_pend <= 1'b0;

         if (stop_ev)                       stop_pend <= 1'b1;
         else if (clr_stop || live_rising)  stop_pend <= 1'b0;

         if (warn_ev)                       warn_pend <= 1'b1;
         else if (clr_warn || live_rising)  warn_pend <= 1'b0;

         if (clr_err)          err_sent <= 1'b1;
         else if (live_rising) err_sent <= 1'b0;

         err_latched <= (live_rising ? '0 : err_latched) | err_in;

         if (live_rising)           drop_cnt <= '0;
         else if (drop_sum[DROP_W]) drop_cnt <= '1;
         else                       drop_cnt <= drop_sum[DROP_W-1:0];
      end
   end

   pulse_frame_tx #(
      .FRAME_LEN (FRAME_LEN),
      .GAP_LEN   (GAP_LEN),
      .CODE_W    (CODE_W)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .code    (code_sel),
      .err_out (err_out),
      .busy    (busy),
      .ready   (ready)
   );

endmodule

// File: tb/tb_error_encoder_mc.sv
// Directed bench for error_encoder_mc: frame shapes, queuing, coalescing, spill boundaries and reset.
module tb_error_encoder_mc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       live_rising;
   logic [3:0] err_in;
   logic       stop_rising;
   logic       stop_falling;
   logic       warn_in;
   logic       err_out;
   logic       busy;
   logic       err_sent;
   logic [3:0] err_latched;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   error_encoder_mc #(
      .N_ERR(4), .FRAME_LEN(4), .GAP_LEN(2),
      .ERR_CODE(1), .STOP_CODE(2), .WARN_CODE(3), .DROP_W(8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .live_rising  (live_rising),
      .err_in       (err_in),
      .stop_rising  (stop_rising),
      .stop_falling (stop_falling),
      .warn_in      (warn_in),
      .err_out      (err_out),
      .busy         (busy),
      .err_sent     (err_sent),
      .err_latched  (err_latched),
      .drop_cnt     (drop_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic new_spill;
      live_rising = 1'b1;
      tick();
      live_rising = 1'b0;
      tick();
   endtask

   // rec[i] holds err_out after the i-th edge; pulses in bit i are sampled at that same edge.
   task automatic run_seq(input logic [3:0] err_lvl, input logic [31:0] stop_r_v,
                          input logic [31:0] stop_f_v, input logic [31:0] warn_v,
                          input logic [31:0] live_v, input int n, output logic [31:0] rec);
      rec = '0;
      for (int i = 0; i < n; i++) begin
         err_in       = err_lvl;
         stop_rising  = stop_r_v[i];
         stop_falling = stop_f_v[i];
         warn_in      = warn_v[i];
         live_rising  = live_v[i];
         tick();
         rec[i] = err_out;
      end
      err_in = '0; stop_rising = 0; stop_falling = 0; warn_in = 0; live_rising = 0;
   endtask

   task automatic test_reset;
      int highs;
      rst_n = 1'b0; live_rising = 0; err_in = '0; stop_rising = 0; stop_falling = 0; warn_in = 0;
      tick();
      n_checks += 5;
      if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err_out: got %b expected 0", err_out); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (err_sent !== 1'b0) begin n_fail++; $display("FAIL reset_err_sent: got %b expected 0", err_sent); end
      if (err_latched !== 4'h0) begin n_fail++; $display("FAIL reset_err_latched: got %h expected 0", err_latched); end
      if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
      tick();
      rst_n = 1'b1;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (err_out === 1'b1 || busy === 1'b1) highs++;
      end
      n_checks++;
      if (highs !== 0) begin n_fail++; $display("FAIL reset_idle: got %0d active cycles expected 0", highs); end
   endtask

   task automatic test_reset_mid;
      int highs;
      err_in = 4'b0001;
      tick();
      tick();
      n_checks++;
      if (err_out !== 1'b1) begin n_fail++; $display("FAIL mid_frame_start: got %b expected 1", err_out); end
      #2 rst_n = 1'b0;
      #1;
      n_checks += 3;
      if (err_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_err_out: got %b expected 0", err_out); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
      if (err_sent !== 1'b0) begin n_fail++; $display("FAIL async_reset_err_sent: got %b expected 0", err_sent); end
      err_in = '0;
      tick();
      rst_n = 1'b1;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (err_out === 1'b1) highs++;
      end
      n_checks++;
      if (highs !== 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d high cycles expected 0", highs); end
   endtask

   task automatic test_err_hold;
      int highs, first, busy_n;
      new_spill();
      err_in = 4'b0010;
      highs = 0; first = -1; busy_n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (err_out === 1'b1) begin
            highs++;
            if (first < 0) first = i;
         end
         if (busy === 1'b1) busy_n++;
      end
      n_checks += 5;
      if (highs !== 1) begin n_fail++; $display("FAIL hold_high_count: got %0d expected 1", highs); end
      if (first !== 1) begin n_fail++; $display("FAIL hold_latency: got %0d expected 1", first); end
      if (busy_n !== 6) begin n_fail++; $display("FAIL hold_busy_len: got %0d expected 6", busy_n); end
      if (err_sent !== 1'b1) begin n_fail++; $display("FAIL hold_err_sent: got %b expected 1", err_sent); end
      if (err_latched !== 4'b0010) begin n_fail++; $display("FAIL hold_err_latched: got %b expected 0010", err_latched); end
      err_in = '0;
      tick();
   endtask

   task automatic test_err_stop;
      logic [31:0] rec;
      new_spill();
      run_seq(4'b0001, 32'h1, 32'h0, 32'h0, 32'h0, 16, rec);
      n_checks += 2;
      if (rec !== 32'h182) begin n_fail++; $display("FAIL err_then_stop: got %h expected 00000182", rec); end
      if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL err_stop_drop: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_coalesce;
      logic [31:0] rec;
      new_spill();
      run_seq(4'b0100, 32'hE, 32'h0, 32'h0, 32'h0, 16, rec);
      n_checks += 2;
      if (rec !== 32'h182) begin n_fail++; $display("FAIL coalesce_frames: got %h expected 00000182", rec); end
      if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL coalesce_drop: got %0d expected 2", drop_cnt); end
   endtask

   task automatic test_warn_after_stop;
      logic [31:0] rec;
      new_spill();
      // Rise and fall in the same cycle count as a single STOP event.
      run_seq(4'b0000, 32'h1, 32'h1, 32'hFFFE, 32'h0, 16, rec);
      n_checks += 2;
      if (rec !== 32'h386) begin n_fail++; $display("FAIL stop_then_warn: got %h expected 00000386", rec); end
      if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL stop_warn_drop: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_live_mid_frame;
      logic [31:0] rec;
      new_spill();
      run_seq(4'b1000, 32'h0, 32'h0, 32'h0, 32'h4, 16, rec);
      n_checks += 4;
      if (rec !== 32'h82) begin n_fail++; $display("FAIL live_mid_frame: got %h expected 00000082", rec); end
      if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL live_drop: got %0d expected 0", drop_cnt); end
      if (err_sent !== 1'b1) begin n_fail++; $display("FAIL live_err_sent: got %b expected 1", err_sent); end
      if (err_latched !== 4'b1000) begin n_fail++; $display("FAIL live_err_latched: got %b expected 1000", err_latched); end
   endtask

   task automatic test_drop_sat;
      logic [31:0] rec;
      new_spill();
      for (int k = 0; k < 13; k++) run_seq(4'b0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32, rec);
      n_checks++;
      if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); end
      new_spill();
      n_checks++;
      if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL drop_live_clear: got %0d expected 0", drop_cnt); end
      repeat (10) tick();
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_err_hold();
      test_err_stop();
      test_coalesce();
      test_warn_after_stop();
      test_live_mid_frame();
      test_drop_sat();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
